// File: rtl/issue_ctrl_if.sv
// Issue-stage bundle: issue-buffer slots A/B, flush/stall controls, and the
// issue decision plus performance counters coming back from issue_ctrl.
interface issue_ctrl_if;
    logic        flush;
    logic        stall;
    logic [1:0]  is_valid;
    logic [4:0]  a_rs1, a_rs2, b_rs1, b_rs2;
    logic        a_rs1_en, a_rs2_en, b_rs1_en, b_rs2_en;
    logic [4:0]  a_rd, b_rd;
    logic        a_we, b_we;
    logic        a_is_load, a_is_mem, a_is_br, a_is_div;
    logic        b_is_load, b_is_mem, b_is_br, b_is_div;
    logic [1:0]  using_num;
    logic        issue_a, issue_b;
    logic        div_busy;
    logic [31:0] cnt_dual, cnt_hold;

    modport master (
        output flush, stall, is_valid,
        output a_rs1, a_rs2, b_rs1, b_rs2, a_rs1_en, a_rs2_en, b_rs1_en, b_rs2_en,
        output a_rd, b_rd, a_we, b_we,
        output a_is_load, a_is_mem, a_is_br, a_is_div,
        output b_is_load, b_is_mem, b_is_br, b_is_div,
        input  using_num, issue_a, issue_b, div_busy, cnt_dual, cnt_hold
    );

    modport slave (
        input  flush, stall, is_valid,
        input  a_rs1, a_rs2, b_rs1, b_rs2, a_rs1_en, a_rs2_en, b_rs1_en, b_rs2_en,
        input  a_rd, b_rd, a_we, b_we,
        input  a_is_load, a_is_mem, a_is_br, a_is_div,
        input  b_is_load, b_is_mem, b_is_br, b_is_div,
        output using_num, issue_a, issue_b, div_busy, cnt_dual, cnt_hold
    );
endinterface

// File: rtl/issue_ctrl.sv
// Dual-issue control: decides how many of the two buffered instructions leave
// this cycle, tracking load-use hazards and an unpipelined divider.
module issue_ctrl #(
    parameter int unsigned DIV_LAT = 8
) (
    input  logic       clk,
    input  logic       rstn,
    issue_ctrl_if.slave bus
);
    typedef enum logic {RUN, DIV_WAIT} state_t;

    localparam logic [3:0] DIV_INIT = 4'(DIV_LAT - 1);

    state_t      state_reg, state_next;
    logic [3:0]  div_cnt_reg, div_cnt_next;
    logic        ld_v_reg, ld_v_next;
    logic [4:0]  ld_rd_reg, ld_rd_next;
    logic [31:0] cnt_dual_reg, cnt_hold_reg;

    logic a_lu, b_lu, b_raw, b_waw, b_struct;
    logic issue_a, issue_b;

    function automatic logic src_hit(input logic en, input logic [4:0] rs, input logic [4:0] rd);
        return en && (rs != 5'd0) && (rs == rd);
    endfunction

    assign a_lu = ld_v_reg && (src_hit(bus.a_rs1_en, bus.a_rs1, ld_rd_reg) ||
                               src_hit(bus.a_rs2_en, bus.a_rs2, ld_rd_reg));
    assign b_lu = ld_v_reg && (src_hit(bus.b_rs1_en, bus.b_rs1, ld_rd_reg) ||
                               src_hit(bus.b_rs2_en, bus.b_rs2, ld_rd_reg));
    assign b_raw = bus.a_we && (src_hit(bus.b_rs1_en, bus.b_rs1, bus.a_rd) ||
                                src_hit(bus.b_rs2_en, bus.b_rs2, bus.a_rd));
    assign b_waw = bus.a_we && bus.b_we && (bus.a_rd == bus.b_rd) && (bus.a_rd != 5'd0);
    // Only one memory port, branches resolve alone, and divides serialise.
    assign b_struct = (bus.a_is_mem && bus.b_is_mem) || bus.a_is_br || bus.b_is_br ||
                      bus.a_is_div || bus.b_is_div;

    // rstn gates issue so the outputs read zero for the whole reset window.
    assign issue_a = rstn && bus.is_valid[1] && !bus.flush && !bus.stall &&
                     (state_reg == RUN) && !a_lu;
    assign issue_b = issue_a && bus.is_valid[0] && !b_lu && !b_raw && !b_waw && !b_struct;

    assign bus.issue_a   = issue_a;
    assign bus.issue_b   = issue_b;
    assign bus.using_num = issue_b ? 2'b10 : (issue_a ? 2'b01 : 2'b00);
    assign bus.div_busy  = (state_reg == DIV_WAIT);
    assign bus.cnt_dual  = cnt_dual_reg;
    assign bus.cnt_hold  = cnt_hold_reg;

    always_comb begin
        state_next   = state_reg;
        div_cnt_next = div_cnt_reg;
        ld_v_next    = ld_v_reg;
        ld_rd_next   = ld_rd_reg;
        if (bus.flush) begin
            state_next   = RUN;
            div_cnt_next = 4'd0;
            ld_v_next    = 1'b0;
        end else begin
            case (state_reg)
                RUN: begin
                    if ((issue_a && bus.a_is_div) || (issue_b && bus.b_is_div)) begin
                        state_next   = DIV_WAIT;
                        div_cnt_next = DIV_INIT;
                    end
                end
                DIV_WAIT: begin
                    // The divider keeps counting through DCache stalls.
                    if (div_cnt_reg == 4'd0) state_next = RUN;
                    else                     div_cnt_next = div_cnt_reg - 4'd1;
                end
                default: state_next = RUN;
            endcase

            if (issue_b && bus.b_is_load && bus.b_we && (bus.b_rd != 5'd0)) begin
                ld_v_next  = 1'b1;
                ld_rd_next = bus.b_rd;
            end else if (issue_a && bus.a_is_load && bus.a_we && (bus.a_rd != 5'd0)) begin
                ld_v_next  = 1'b1;
                ld_rd_next = bus.a_rd;
            end else if (!bus.stall) begin
                ld_v_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= RUN;
            div_cnt_reg  <= 4'd0;
            ld_v_reg     <= 1'b0;
            ld_rd_reg    <= 5'd0;
            cnt_dual_reg <= 32'd0;
            cnt_hold_reg <= 32'd0;
        end else begin
            state_reg   <= state_next;
            div_cnt_reg <= div_cnt_next;
            ld_v_reg    <= ld_v_next;
            ld_rd_reg   <= ld_rd_next;
            if (issue_b)
                cnt_dual_reg <= cnt_dual_reg + 32'd1;
            if (bus.is_valid[1] && !issue_a)
                cnt_hold_reg <= cnt_hold_reg + 32'd1;
        end
    end
endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_issue_ctrl;
    logic clk = 1'b0;
    logic rstn;
    int   tests = 0;
    int   fails = 0;

    issue_ctrl_if bus ();
    issue_ctrl #(.DIV_LAT(8)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    always #5 clk = ~clk;

    logic [1:0]  un_q[$];
    logic        busy_q[$];
    logic [31:0] dual_q[$];
    logic [31:0] hold_q[$];
    string       name_q[$];
    logic [31:0] exp_dual = 32'd0;
    logic [31:0] exp_hold = 32'd0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (un_q.size() != 0) begin
            logic [1:0]  eu;
            logic        eb;
            logic [31:0] ed, eh;
            string       nm;
            eu = un_q.pop_front();
            eb = busy_q.pop_front();
            ed = dual_q.pop_front();
            eh = hold_q.pop_front();
            nm = name_q.pop_front();
            check({nm, ".using_num"}, 32'(bus.using_num), 32'(eu));
            check({nm, ".issue_a"},   32'(bus.issue_a),   32'(eu != 2'b00));
            check({nm, ".issue_b"},   32'(bus.issue_b),   32'(eu == 2'b10));
            check({nm, ".div_busy"},  32'(bus.div_busy),  32'(eb));
            check({nm, ".cnt_dual"},  bus.cnt_dual, ed);
            check({nm, ".cnt_hold"},  bus.cnt_hold, eh);
            $display("[TB] %-14s using_num=%b div_busy=%b cnt_dual=%0d cnt_hold=%0d",
                     nm, bus.using_num, bus.div_busy, bus.cnt_dual, bus.cnt_hold);
        end
    end

    task automatic clr();
        bus.flush = 0; bus.stall = 0; bus.is_valid = 2'b00;
        bus.a_rs1 = 0; bus.a_rs2 = 0; bus.b_rs1 = 0; bus.b_rs2 = 0;
        bus.a_rs1_en = 0; bus.a_rs2_en = 0; bus.b_rs1_en = 0; bus.b_rs2_en = 0;
        bus.a_rd = 0; bus.b_rd = 0; bus.a_we = 0; bus.b_we = 0;
        bus.a_is_load = 0; bus.a_is_mem = 0; bus.a_is_br = 0; bus.a_is_div = 0;
        bus.b_is_load = 0; bus.b_is_mem = 0; bus.b_is_br = 0; bus.b_is_div = 0;
    endtask

    // Expectation for the current cycle; counters are those visible this cycle.
    task automatic step(input logic [1:0] eu, input logic eb, input string nm);
        un_q.push_back(eu);
        busy_q.push_back(eb);
        dual_q.push_back(exp_dual);
        hold_q.push_back(exp_hold);
        name_q.push_back(nm);
        if (rstn) begin
            if (eu == 2'b10) exp_dual++;
            if (bus.is_valid[1] && eu == 2'b00) exp_hold++;
        end
        @(posedge clk);
        #1;
        clr();
    endtask

    initial begin
        rstn = 1'b0;
        clr();
        @(posedge clk); #1;
        bus.is_valid = 2'b11;
        step(2'b00, 1'b0, "reset");
        rstn = 1'b1;

        // Independent pair dual-issues.
        bus.is_valid = 2'b11; bus.a_we = 1; bus.a_rd = 3; bus.b_rs1 = 4; bus.b_rs1_en = 1;
        step(2'b10, 1'b0, "alu_pair");
        // RAW between slots splits the pair.
        bus.is_valid = 2'b11; bus.a_we = 1; bus.a_rd = 5; bus.b_rs1 = 5; bus.b_rs1_en = 1;
        step(2'b01, 1'b0, "raw_pair");
        bus.is_valid = 2'b10; bus.a_rs1 = 5; bus.a_rs1_en = 1;
        step(2'b01, 1'b0, "raw_follow");
        // Register 0 never hazards.
        bus.is_valid = 2'b11; bus.a_we = 1; bus.a_rd = 0; bus.b_rs1 = 0; bus.b_rs1_en = 1;
        step(2'b10, 1'b0, "r0_pair");
        // Load-use on slot A.
        bus.is_valid = 2'b10; bus.a_is_load = 1; bus.a_is_mem = 1; bus.a_we = 1; bus.a_rd = 7;
        step(2'b01, 1'b0, "load7");
        bus.is_valid = 2'b10; bus.a_rs2 = 7; bus.a_rs2_en = 1;
        step(2'b00, 1'b0, "lu_hold");
        bus.is_valid = 2'b10; bus.a_rs2 = 7; bus.a_rs2_en = 1;
        step(2'b01, 1'b0, "lu_release");
        // Load-use on slot B only.
        bus.is_valid = 2'b10; bus.a_is_load = 1; bus.a_is_mem = 1; bus.a_we = 1; bus.a_rd = 9;
        step(2'b01, 1'b0, "load9");
        bus.is_valid = 2'b11; bus.a_rs1 = 2; bus.a_rs1_en = 1; bus.b_rs1 = 9; bus.b_rs1_en = 1;
        step(2'b01, 1'b0, "lu_slot_b");
        // WAW and structural blocks on B.
        bus.is_valid = 2'b11; bus.a_we = 1; bus.a_rd = 6; bus.b_we = 1; bus.b_rd = 6;
        step(2'b01, 1'b0, "waw");
        bus.is_valid = 2'b11; bus.a_is_mem = 1; bus.b_is_mem = 1;
        step(2'b01, 1'b0, "two_mem");
        bus.is_valid = 2'b11; bus.a_is_br = 1;
        step(2'b01, 1'b0, "a_branch");
        bus.is_valid = 2'b11; bus.b_is_br = 1;
        step(2'b01, 1'b0, "b_branch");
        bus.is_valid = 2'b11; bus.b_is_div = 1;
        step(2'b01, 1'b0, "b_div_block");
        bus.is_valid = 2'b10;
        step(2'b01, 1'b0, "after_b_div");
        // Stall freezes issue and holds the load record.
        bus.is_valid = 2'b10; bus.a_is_load = 1; bus.a_is_mem = 1; bus.a_we = 1; bus.a_rd = 8;
        step(2'b01, 1'b0, "load8");
        bus.is_valid = 2'b10; bus.stall = 1; bus.a_rs1 = 8; bus.a_rs1_en = 1;
        step(2'b00, 1'b0, "stall");
        bus.is_valid = 2'b10; bus.a_rs1 = 8; bus.a_rs1_en = 1;
        step(2'b00, 1'b0, "lu_after_stall");
        bus.is_valid = 2'b10; bus.a_rs1 = 8; bus.a_rs1_en = 1;
        step(2'b01, 1'b0, "lu_clear");
        // Divide occupies 8 cycles after issue, stall does not extend it.
        bus.is_valid = 2'b11; bus.a_is_div = 1;
        step(2'b01, 1'b0, "div_issue");
        for (int i = 1; i <= 8; i++) begin
            bus.is_valid = 2'b10;
            if (i == 3) bus.stall = 1;
            step(2'b00, 1'b1, $sformatf("div_wait%0d", i));
        end
        bus.is_valid = 2'b10;
        step(2'b01, 1'b0, "div_resume");
        // Flush beats stall during DIV_WAIT and clears a live load record.
        bus.is_valid = 2'b10; bus.a_is_div = 1; bus.a_is_load = 1; bus.a_is_mem = 1;
        bus.a_we = 1; bus.a_rd = 10;
        step(2'b01, 1'b0, "ld_div");
        bus.is_valid = 2'b10; bus.stall = 1; bus.flush = 1;
        step(2'b00, 1'b1, "flush_stall");
        bus.is_valid = 2'b10; bus.a_rs1 = 10; bus.a_rs1_en = 1;
        step(2'b01, 1'b0, "post_flush");
        // Two loads: only A issues and its rd is recorded.
        bus.is_valid = 2'b11; bus.a_is_load = 1; bus.a_is_mem = 1; bus.a_we = 1; bus.a_rd = 11;
        bus.b_is_load = 1; bus.b_is_mem = 1; bus.b_we = 1; bus.b_rd = 12;
        step(2'b01, 1'b0, "two_loads");
        bus.is_valid = 2'b11; bus.a_rs1 = 12; bus.a_rs1_en = 1; bus.b_rs2 = 11; bus.b_rs2_en = 1;
        step(2'b01, 1'b0, "ld_rd_is_a");
        // Reset mid divide aborts the wait.
        bus.is_valid = 2'b10; bus.a_is_div = 1;
        step(2'b01, 1'b0, "div2_issue");
        bus.is_valid = 2'b10;
        step(2'b00, 1'b1, "div2_wait");
        rstn = 1'b0;
        exp_dual = 32'd0;
        exp_hold = 32'd0;
        bus.is_valid = 2'b10;
        step(2'b00, 1'b0, "reset_mid_div");
        rstn = 1'b1;
        bus.is_valid = 2'b10;
        step(2'b01, 1'b0, "post_reset");

        repeat (3) @(negedge clk);
        tests++;
        if (un_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", un_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/issue_ctrl.md
ISSUE_CTRL -- requirements
Module: issue_ctrl

Interface
REQ-001 Parameter DIV_LAT, default 8: cycles a divide occupies the divider after issue; legal range 2..15.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 flush  input  1  branch-mispredict flush of the front end and issue stage.
REQ-005 stall  input  1  DCache stall; freezes issue.
REQ-006 is_valid  input  2  issue-buffer occupancy; bit1 = slot A valid, bit0 = slot B valid; 2'b01 never occurs.
REQ-007 a_rs1, a_rs2, b_rs1, b_rs2  input  5 each  source register numbers of slots A/B.
REQ-008 a_rs1_en, a_rs2_en, b_rs1_en, b_rs2_en  input  1 each  source actually read.
REQ-009 a_rd, b_rd  input  5 each  destination registers; a_we, b_we  input  1 each  register write enable.
REQ-010 a_is_load, a_is_mem, a_is_br, a_is_div; b_* same  input  1 each  class flags (load implies mem).
REQ-011 using_num  output  2  instructions consumed this cycle: 2'b00 none, 2'b01 one (A), 2'b10 two (A and B); 2'b11 never driven.
REQ-012 issue_a, issue_b  output  1 each  slot issued this cycle; equal to using_num != 0 and using_num == 2'b10 respectively.
REQ-013 div_busy  output  1  high while state is DIV_WAIT.
REQ-014 cnt_dual, cnt_hold  output  32 each  performance counters.

Function
REQ-015 using_num, issue_a, issue_b are combinational from inputs and registered state in the same cycle (zero latency); all state is registered.
REQ-016 State machine: RUN, DIV_WAIT; divider counter div_cnt, 4 bits.
REQ-017 In RUN, when slot A or B issues with is_div: next state DIV_WAIT, div_cnt <= DIV_LAT-1.
REQ-018 In DIV_WAIT, div_cnt decrements every cycle regardless of stall; at div_cnt == 0 the next state is RUN; no issue occurs in DIV_WAIT.
REQ-019 Load record: registered ld_v, ld_rd; on a cycle that issues a load with we=1 and rd!=0, ld_v<=1, ld_rd<=that rd (slot B's load takes priority if both slots are loads, which REQ-024 forbids); otherwise, on any non-stall cycle, ld_v<=0.
REQ-020 During stall the load record holds its value.
REQ-021 Slot A issues when: is_valid[1], no flush, no stall, state RUN, and no load-use hazard (ld_v and an enabled A source != 0 equal to ld_rd).
REQ-022 Slot B issues only when slot A issues, is_valid[0], and no load-use hazard on B against the load record.
REQ-023 Slot B is also blocked when: A writes (a_we, a_rd != 0) a register that B reads through an enabled source; or a_we and b_we with a_rd == b_rd != 0.
REQ-024 Slot B is also blocked when: both a_is_mem and b_is_mem; a_is_br; b_is_br; a_is_div or b_is_div.
REQ-025 Register 0 never creates a hazard.
REQ-026 flush takes priority over stall: using_num = 0; next cycle state RUN, div_cnt = 0, ld_v = 0.
REQ-027 cnt_dual increments on each cycle with using_num == 2'b10; cnt_hold increments on each cycle with is_valid[1] = 1 and using_num == 2'b00; both wrap at 2^32 and are unaffected by flush.

Reset
REQ-028 On rstn low, immediately: state RUN, div_cnt 0, ld_v 0, ld_rd 0, cnt_dual 0, cnt_hold 0; outputs using_num 0, issue_a 0, issue_b 0, div_busy 0.
REQ-029 Reset asserted mid-DIV_WAIT aborts the wait; after release the first valid slot A issues the same cycle.

Verification
REQ-030 Independent ALU ops: A rd=3, B rs1=4, is_valid=11 -> using_num=10, cnt_dual +1.
REQ-031 RAW pair: A we rd=5, B rs1=5 en=1 -> using_num=01; next cycle B (now A) issues alone.
REQ-032 Load-use: issue load rd=7; next cycle A rs2=7 en=1 -> using_num=00, cnt_hold +1; following cycle -> using_num=01.
REQ-033 Divide with DIV_LAT=8: A is_div issues at cycle T -> using_num=00 and div_busy=1 for cycles T+1..T+8, issue resumes at T+9.
REQ-034 stall=1 and flush=1 together during DIV_WAIT with ld_v=1 -> using_num=00; next cycle state RUN, ld_v=0, div_busy=0.
REQ-035 Two loads, is_valid=11 -> using_num=01; ld_rd captures slot A's rd.
